// File: rtl/light_package.sv
// Shared lamp/state types and default timing for the phase round-robin controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package light_package;

    // Lamp color per phase head; red is the all-zero safe value.
    typedef enum logic [1:0] {
        LAMP_RED    = 2'd0,
        LAMP_YELLOW = 2'd1,
        LAMP_GREEN  = 2'd2
    } colors_t;

    // Controller state.
    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        ALLRED = 2'd2
    } tlc_state_t;

    // Default timing constants.
    localparam int DEF_N_PHASES      = 5;
    localparam int DEF_GAP_CYCLES    = 5;
    localparam int DEF_MAX_CYCLES    = 10;
    localparam int DEF_YELLOW_CYCLES = 2;
    localparam int DEF_ALLRED_CYCLES = 1;

    // Largest of four durations; sizes the shared counter width.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/tlc_rr_arbiter.sv
// Round-robin first-set search over per-phase requests, starting after 'last'.
// Latency: combinational.
// Backpressure: none; grant_valid low when no request is present.
module tlc_rr_arbiter #(
    parameter int N_PHASES = 5
) (
    input  logic [N_PHASES-1:0]         req,
    input  logic [$clog2(N_PHASES)-1:0] last,
    output logic [$clog2(N_PHASES)-1:0] grant_idx,
    output logic                        grant_valid
);

    localparam int IW = $clog2(N_PHASES);

    logic [IW:0] sum;

    // Walk offsets from farthest to nearest so the nearest set bit after 'last' wins; offset N is 'last' itself.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        sum         = '0;
        for (int off = N_PHASES; off >= 1; off--) begin
            sum = {1'b0, last} + (IW+1)'(off);
            if (sum >= (IW+1)'(N_PHASES)) begin
                sum = sum - (IW+1)'(N_PHASES);
            end
            if (req[sum[IW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/tlc_phase_rr_controller.sv
// Round-robin traffic phase controller: green (gap/max-out), yellow, all-red, re-arbitrate.
// Latency: registered Moore outputs; a request is granted on the edge ending all-red clearance.
// Backpressure: none; requests absent in all-red leave it idle. Optional macro TLC_PREEMPT_EN adds preemption.
module tlc_phase_rr_controller
    import light_package::*;
#(
    parameter int N_PHASES      = DEF_N_PHASES,
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int MAX_CYCLES    = DEF_MAX_CYCLES,
    parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
    parameter int ALLRED_CYCLES = DEF_ALLRED_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [N_PHASES-1:0]           phase_req,
`ifdef TLC_PREEMPT_EN
    input  logic                          preempt,
    input  logic [$clog2(N_PHASES)-1:0]   preempt_phase,
`endif
    output logic [N_PHASES-1:0][1:0]      lights,
    output logic [$clog2(N_PHASES)-1:0]   cur_phase,
    output logic                          busy
);

    localparam int IW = $clog2(N_PHASES);
    localparam int CW = $clog2(max4(GAP_CYCLES, MAX_CYCLES, YELLOW_CYCLES, ALLRED_CYCLES) + 1);

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] GAP_LIM  = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] MAX_LIM  = CW'(MAX_CYCLES);
    localparam logic [CW-1:0] YEL_LAST = CW'(YELLOW_CYCLES - 1);
    localparam logic [CW-1:0] ALR_LAST = CW'(ALLRED_CYCLES - 1);

    tlc_state_t              state_q, state_d;
    logic [IW-1:0]           cur_q, cur_d;
    logic [CW-1:0]           gap_q, gap_d;
    logic [CW-1:0]           max_q, max_d;
    logic [CW-1:0]           yel_q, yel_d;
    logic [CW-1:0]           alr_q, alr_d;
    logic [N_PHASES-1:0][1:0] lights_q, lights_d;
    logic                    busy_q, busy_d;

    logic [N_PHASES-1:0]     own_mask;
    logic                    own_req;
    logic                    other_req;
    logic [IW-1:0]           grant_idx;
    logic                    grant_valid;

    logic                    pre_kick;
    logic                    pre_hold;
    logic                    pre_grant;
    logic [IW-1:0]           pre_idx;

    assign own_mask  = N_PHASES'(1) << cur_q;
    assign own_req   = phase_req[cur_q];
    assign other_req = |(phase_req & ~own_mask);

`ifdef TLC_PREEMPT_EN
    logic pre_valid;
    // Out-of-range preempt targets are ignored rather than granting a nonexistent phase.
    assign pre_valid = preempt && (int'(preempt_phase) < N_PHASES);
    assign pre_kick  = pre_valid && (preempt_phase != cur_q);
    assign pre_hold  = pre_valid && (preempt_phase == cur_q);
    assign pre_grant = pre_valid;
    assign pre_idx   = preempt_phase;
`else
    assign pre_kick  = 1'b0;
    assign pre_hold  = 1'b0;
    assign pre_grant = 1'b0;
    assign pre_idx   = '0;
`endif

    // In all-red cur_q still holds the last served phase, so it doubles as the round-robin pointer.
    tlc_rr_arbiter #(
        .N_PHASES (N_PHASES)
    ) u_arb (
        .req         (phase_req),
        .last        (cur_q),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Next-state, counter and output decode.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        gap_d   = gap_q;
        max_d   = max_q;
        yel_d   = yel_q;
        alr_d   = alr_q;

        unique case (state_q)
            GREEN: begin
                if (pre_kick) begin
                    state_d = YELLOW;
                    gap_d   = '0;
                    max_d   = '0;
                    yel_d   = '0;
                end else if (pre_hold) begin
                    gap_d = '0;
                    max_d = '0;
                end else if ((gap_q == GAP_LIM) || (max_q == MAX_LIM)) begin
                    state_d = YELLOW;
                    gap_d   = '0;
                    max_d   = '0;
                    yel_d   = '0;
                end else begin
                    // Once armed, both counters free-run to their limit; a returning request does not disarm.
                    if (gap_q != '0) begin
                        gap_d = gap_q + ONE;
                    end else if (!own_req) begin
                        gap_d = ONE;
                    end
                    if (max_q != '0) begin
                        max_d = max_q + ONE;
                    end else if (own_req && other_req) begin
                        max_d = ONE;
                    end
                end
            end
            YELLOW: begin
                if (yel_q == YEL_LAST) begin
                    state_d = ALLRED;
                    alr_d   = '0;
                end else begin
                    yel_d = yel_q + ONE;
                end
            end
            ALLRED: begin
                // Clearance counter saturates at its last value; from then on arbitrate every cycle.
                if (alr_q != ALR_LAST) begin
                    alr_d = alr_q + ONE;
                end else if (pre_grant) begin
                    state_d = GREEN;
                    cur_d   = pre_idx;
                end else if (grant_valid) begin
                    state_d = GREEN;
                    cur_d   = grant_idx;
                end
            end
            default: begin
                state_d = ALLRED;
                alr_d   = ALR_LAST;
            end
        endcase

        busy_d = (state_d != ALLRED);
        for (int i = 0; i < N_PHASES; i++) begin
            lights_d[i] = LAMP_RED;
            if (IW'(i) == cur_d) begin
                if (state_d == GREEN) begin
                    lights_d[i] = LAMP_GREEN;
                end else if (state_d == YELLOW) begin
                    lights_d[i] = LAMP_YELLOW;
                end
            end
        end
    end

    // State and registered outputs; reset parks in completed all-red with phase 0 next in line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ALLRED;
            cur_q    <= IW'(N_PHASES - 1);
            gap_q    <= '0;
            max_q    <= '0;
            yel_q    <= '0;
            alr_q    <= ALR_LAST;
            lights_q <= {N_PHASES{LAMP_RED}};
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            gap_q    <= gap_d;
            max_q    <= max_d;
            yel_q    <= yel_d;
            alr_q    <= alr_d;
            lights_q <= lights_d;
            busy_q   <= busy_d;
        end
    end

    assign lights    = lights_q;
    assign cur_phase = cur_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_tlc_phase_rr_controller.sv
// Directed table-driven bench for the phase round-robin controller.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_tlc_phase_rr_controller;
    import light_package::*;

    localparam int N = 5;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [N-1:0]        phase_req;
    logic [N-1:0][1:0]   lights;
    logic [2:0]          cur_phase;
    logic                busy;
`ifdef TLC_PREEMPT_EN
    logic                preempt;
    logic [2:0]          preempt_phase;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        int           n;
        int           cur;
        logic [1:0]   col;
        logic         busy;
    } vec_t;

    vec_t vecs[$];

    tlc_phase_rr_controller dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .phase_req     (phase_req),
`ifdef TLC_PREEMPT_EN
        .preempt       (preempt),
        .preempt_phase (preempt_phase),
`endif
        .lights        (lights),
        .cur_phase     (cur_phase),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic vec_t v(input logic r, input logic [N-1:0] q, input int n,
                               input int c, input logic [1:0] col, input logic b);
        vec_t x;
        x.rst = r; x.req = q; x.n = n; x.cur = c; x.col = col; x.busy = b;
        return x;
    endfunction

    function automatic logic [2*N-1:0] exp_l(input int cur, input logic [1:0] col);
        logic [2*N-1:0] r;
        r = {N{LAMP_RED}};
        r[cur*2 +: 2] = col;
        return r;
    endfunction

    task automatic check(input string tag, input logic [2*N-1:0] el, input int ec, input logic eb);
        checks++;
        if (lights !== el) begin
            errors++;
            $display("FAIL %s lights got=%h exp=%h", tag, lights, el);
        end
        checks++;
        if (cur_phase !== 3'(ec)) begin
            errors++;
            $display("FAIL %s cur_phase got=%0d exp=%0d", tag, cur_phase, ec);
        end
        checks++;
        if (busy !== eb) begin
            errors++;
            $display("FAIL %s busy got=%b exp=%b", tag, busy, eb);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        reset_n   = 1'b0;
        phase_req = r;
`ifdef TLC_PREEMPT_EN
        preempt       = 1'b0;
        preempt_phase = 3'd0;
`endif
        tick();
        check("reset", exp_l(0, LAMP_RED), N-1, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        phase_req = '0;
`ifdef TLC_PREEMPT_EN
        preempt       = 1'b0;
        preempt_phase = 3'd0;
`endif

        // Single requester, gap-out after drop, then idle.
        vecs.push_back(v(1, 5'h01, 3, 0, LAMP_GREEN,  1));
        vecs.push_back(v(0, 5'h00, 5, 0, LAMP_GREEN,  1));
        vecs.push_back(v(0, 5'h00, 2, 0, LAMP_YELLOW, 1));
        vecs.push_back(v(0, 5'h00, 3, 0, LAMP_RED,    0));
        // Two requesters: max-out after 11 green cycles, then phase 1.
        vecs.push_back(v(1, 5'h03, 11, 0, LAMP_GREEN,  1));
        vecs.push_back(v(0, 5'h03, 2,  0, LAMP_YELLOW, 1));
        vecs.push_back(v(0, 5'h03, 1,  0, LAMP_RED,    0));
        vecs.push_back(v(0, 5'h03, 3,  1, LAMP_GREEN,  1));
        // All five held: 0,1,2,3,4,0.
        for (int p = 0; p < N; p++) begin
            vecs.push_back(v(p == 0, 5'h1F, 11, p, LAMP_GREEN,  1));
            vecs.push_back(v(0,      5'h1F, 2,  p, LAMP_YELLOW, 1));
            vecs.push_back(v(0,      5'h1F, 1,  p, LAMP_RED,    0));
        end
        vecs.push_back(v(0, 5'h1F, 1, 0, LAMP_GREEN, 1));
        // Phase 3: one-cycle drop does not disarm gap; lone requester re-granted.
        vecs.push_back(v(1, 5'h08, 2, 3, LAMP_GREEN,  1));
        vecs.push_back(v(0, 5'h00, 1, 3, LAMP_GREEN,  1));
        vecs.push_back(v(0, 5'h08, 4, 3, LAMP_GREEN,  1));
        vecs.push_back(v(0, 5'h08, 2, 3, LAMP_YELLOW, 1));
        vecs.push_back(v(0, 5'h08, 1, 3, LAMP_RED,    0));
        vecs.push_back(v(0, 5'h08, 2, 3, LAMP_GREEN,  1));
        // No requests: idle all-red; then idle phases skipped.
        vecs.push_back(v(1, 5'h00, 3, 4, LAMP_RED,   0));
        vecs.push_back(v(0, 5'h04, 1, 2, LAMP_GREEN, 1));

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset(vecs[i].req);
            phase_req = vecs[i].req;
            for (int k = 0; k < vecs[i].n; k++) begin
                tick();
                check($sformatf("vec%0d.%0d", i, k), exp_l(vecs[i].cur, vecs[i].col),
                      vecs[i].cur, vecs[i].busy);
            end
        end

        // Asynchronous reset mid-yellow, then phase-0 priority restored.
        do_reset(5'h01);
        tick();
        check("ar_green", exp_l(0, LAMP_GREEN), 0, 1'b1);
        phase_req = 5'h00;
        repeat (6) tick();
        check("ar_yellow", exp_l(0, LAMP_YELLOW), 0, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        check("ar_async", exp_l(0, LAMP_RED), N-1, 1'b0);
        phase_req = 5'h11;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("ar_regrant", exp_l(0, LAMP_GREEN), 0, 1'b1);

`ifdef TLC_PREEMPT_EN
        // Preempt phase 2 in favour of 4; 4 holds green with no request while preempt is high.
        do_reset(5'h04);
        tick();
        check("pe_g2", exp_l(2, LAMP_GREEN), 2, 1'b1);
        preempt       = 1'b1;
        preempt_phase = 3'd4;
        tick();
        check("pe_y2a", exp_l(2, LAMP_YELLOW), 2, 1'b1);
        tick();
        check("pe_y2b", exp_l(2, LAMP_YELLOW), 2, 1'b1);
        tick();
        check("pe_r", exp_l(2, LAMP_RED), 2, 1'b0);
        tick();
        check("pe_g4", exp_l(4, LAMP_GREEN), 4, 1'b1);
        phase_req = 5'h00;
        for (int k = 0; k < 50; k++) begin
            tick();
            check($sformatf("pe_hold%0d", k), exp_l(4, LAMP_GREEN), 4, 1'b1);
        end
        preempt = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("pe_rel%0d", k), exp_l(4, LAMP_GREEN), 4, 1'b1);
        end
        tick();
        check("pe_gapout", exp_l(4, LAMP_YELLOW), 4, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
